// File: rtl/sdr_bus_width_conv_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sdr_bus_width_conv_if                                             |
// | Brief  : application / transfer-controller bus bundle for the width conv.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface sdr_bus_width_conv_if;
  logic [1:0]  sdr_width;
  logic [31:0] app_wr_data;
  logic        app_wr_next;
  logic [31:0] app_rd_data;
  logic        app_rd_valid;
  logic        x2a_wrstart;
  logic        x2a_wrnext;
  logic        x2a_wrlast;
  logic [31:0] a2x_wrdt;
  logic        x2a_rdstart;
  logic        x2a_rdok;
  logic        x2a_rdlast;
  logic [31:0] x2a_rddt;
  logic [1:0]  wr_xfr_count;
  logic [1:0]  rd_xfr_count;

  modport master (
    output sdr_width, app_wr_data, x2a_wrstart, x2a_wrnext, x2a_wrlast,
           x2a_rdstart, x2a_rdok, x2a_rdlast, x2a_rddt,
    input  app_wr_next, app_rd_data, app_rd_valid, a2x_wrdt,
           wr_xfr_count, rd_xfr_count
  );

  modport slave (
    input  sdr_width, app_wr_data, x2a_wrstart, x2a_wrnext, x2a_wrlast,
           x2a_rdstart, x2a_rdok, x2a_rdlast, x2a_rddt,
    output app_wr_next, app_rd_data, app_rd_valid, a2x_wrdt,
           wr_xfr_count, rd_xfr_count
  );
endinterface
`default_nettype wire

// File: rtl/sdr_bus_width_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sdr_bus_width_conv                                                |
// | Brief  : splits 32-bit app words into 32/16/8-bit SDRAM beats and back.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module sdr_bus_width_conv (
  input  logic                  clk,
  input  logic                  reset,
  sdr_bus_width_conv_if.slave   bus
);

  logic [1:0]  w_last_idx;
  logic [1:0]  r_wr_cnt;
  logic [1:0]  r_rd_cnt;
  logic [31:0] r_saved;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;
  logic [31:0] w_wrdt;
  logic [31:0] w_merged;
  logic        w_rd_done;

  always_comb begin
    case (bus.sdr_width)
      2'b00:   w_last_idx = 2'd0;
      2'b01:   w_last_idx = 2'd1;
      default: w_last_idx = 2'd3;
    endcase
  end

  // Out-of-range counts only arise from an unsupported mid-burst width change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_cnt <= 2'd0;
    end else if (bus.x2a_wrstart) begin
      r_wr_cnt <= 2'd0;
    end else if (bus.x2a_wrnext) begin
      if (bus.x2a_wrlast || (r_wr_cnt >= w_last_idx))
        r_wr_cnt <= 2'd0;
      else
        r_wr_cnt <= r_wr_cnt + 2'd1;
    end else if (r_wr_cnt > w_last_idx) begin
      r_wr_cnt <= 2'd0;
    end
  end

  always_comb begin
    w_wrdt = 32'h0;
    case (bus.sdr_width)
      2'b00: w_wrdt = bus.app_wr_data;
      2'b01: w_wrdt = {16'h0, r_wr_cnt[0] ? bus.app_wr_data[31:16] : bus.app_wr_data[15:0]};
      default: begin
        case (r_wr_cnt)
          2'd0:    w_wrdt = {24'h0, bus.app_wr_data[7:0]};
          2'd1:    w_wrdt = {24'h0, bus.app_wr_data[15:8]};
          2'd2:    w_wrdt = {24'h0, bus.app_wr_data[23:16]};
          default: w_wrdt = {24'h0, bus.app_wr_data[31:24]};
        endcase
      end
    endcase
  end

  always_comb begin
    w_merged = r_saved;
    case (bus.sdr_width)
      2'b00: w_merged = bus.x2a_rddt;
      2'b01: begin
        if (r_rd_cnt[0]) w_merged[31:16] = bus.x2a_rddt[15:0];
        else             w_merged[15:0]  = bus.x2a_rddt[15:0];
      end
      default: begin
        case (r_rd_cnt)
          2'd0:    w_merged[7:0]   = bus.x2a_rddt[7:0];
          2'd1:    w_merged[15:8]  = bus.x2a_rddt[7:0];
          2'd2:    w_merged[23:16] = bus.x2a_rddt[7:0];
          default: w_merged[31:24] = bus.x2a_rddt[7:0];
        endcase
      end
    endcase
  end

  assign w_rd_done = bus.x2a_rdok && ((r_rd_cnt == w_last_idx) || bus.x2a_rdlast);

  // A start strobe abandons any partial word, so a beat in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_cnt   <= 2'd0;
      r_saved    <= 32'h0;
      r_rd_data  <= 32'h0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (bus.x2a_rdstart) begin
        r_rd_cnt <= 2'd0;
        r_saved  <= 32'h0;
      end else if (bus.x2a_rdok) begin
        if (w_rd_done) begin
          r_rd_cnt   <= 2'd0;
          r_saved    <= 32'h0;
          r_rd_data  <= w_merged;
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_cnt <= r_rd_cnt + 2'd1;
          r_saved  <= w_merged;
        end
      end else if (r_rd_cnt > w_last_idx) begin
        r_rd_cnt <= 2'd0;
      end
    end
  end

  assign bus.a2x_wrdt     = w_wrdt;
  assign bus.app_wr_next  = bus.x2a_wrnext && ((r_wr_cnt == w_last_idx) || bus.x2a_wrlast);
  assign bus.app_rd_data  = r_rd_data;
  assign bus.app_rd_valid = r_rd_valid;
  assign bus.wr_xfr_count = r_wr_cnt;
  assign bus.rd_xfr_count = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdr_bus_width_conv.sv
`default_nettype none
// Directed bench for sdr_bus_width_conv: queue-based reference model checked
// every cycle, plus literal expectations for the worked examples.
module tb_sdr_bus_width_conv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdr_bus_width_conv_if bus ();

  sdr_bus_width_conv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int n_of(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input int n);
    return (n == 1) ? 32'hFFFF_FFFF : (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  // Reference model: write beat index, and read beats collected for the current word.
  int          m_wr_idx   = 0;
  logic [31:0] m_beats[$];
  logic [31:0] m_rd_data  = 32'h0;
  logic        m_rd_valid = 1'b0;
  bit          m_live     = 1'b0;

  initial forever begin
    int n;
    logic [31:0] w;
    @(posedge clk);
    n = n_of(bus.sdr_width);
    if (reset) begin
      m_wr_idx   = 0;
      m_beats.delete();
      m_rd_data  = 32'h0;
      m_rd_valid = 1'b0;
      m_live     = 1'b1;
    end else begin
      if (bus.x2a_wrstart)     m_wr_idx = 0;
      else if (bus.x2a_wrnext) m_wr_idx = bus.x2a_wrlast ? 0 : (m_wr_idx + 1) % n;
      m_rd_valid = 1'b0;
      if (bus.x2a_rdstart) begin
        m_beats.delete();
      end else if (bus.x2a_rdok) begin
        m_beats.push_back(bus.x2a_rddt & lane_mask(n));
        if (bus.x2a_rdlast || m_beats.size() == n) begin
          w = 32'h0;
          foreach (m_beats[i]) w = w | (m_beats[i] << (i * (32 / n)));
          m_rd_data  = w;
          m_rd_valid = 1'b1;
          m_beats.delete();
        end
      end
    end
  end

  initial forever begin
    int n;
    logic [31:0] exp_wrdt;
    logic        exp_next;
    @(negedge clk);
    if (m_live) begin
      n        = n_of(bus.sdr_width);
      exp_wrdt = (bus.app_wr_data >> (m_wr_idx * (32 / n))) & lane_mask(n);
      exp_next = bus.x2a_wrnext && ((m_wr_idx == n - 1) || bus.x2a_wrlast);
      chk("model_wr_count", 32'(bus.wr_xfr_count), 32'(m_wr_idx));
      chk("model_rd_count", 32'(bus.rd_xfr_count), 32'(m_beats.size()));
      chk("model_a2x_wrdt", bus.a2x_wrdt, exp_wrdt);
      chk("model_app_wr_next", 32'(bus.app_wr_next), 32'(exp_next));
      chk("model_app_rd_valid", 32'(bus.app_rd_valid), 32'(m_rd_valid));
      chk("model_app_rd_data", bus.app_rd_data, m_rd_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_beat(input logic [31:0] d, input logic last);
    bus.x2a_rdok   = 1'b1;
    bus.x2a_rddt   = d;
    bus.x2a_rdlast = last;
    step();
    bus.x2a_rdok   = 1'b0;
    bus.x2a_rdlast = 1'b0;
  endtask

  logic [7:0] wb [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] rb [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};

  initial begin
    reset           = 1'b1;
    bus.sdr_width   = 2'b01;
    bus.app_wr_data = 32'hA1B2_C3D4;
    bus.x2a_wrstart = 1'b0;
    bus.x2a_wrnext  = 1'b0;
    bus.x2a_wrlast  = 1'b0;
    bus.x2a_rdstart = 1'b0;
    bus.x2a_rdok    = 1'b0;
    bus.x2a_rdlast  = 1'b0;
    bus.x2a_rddt    = 32'h0;
    step();
    step();
    chk("rst_rd_valid", 32'(bus.app_rd_valid), 32'h0);
    chk("rst_rd_data", bus.app_rd_data, 32'h0);
    chk("rst_wr_count", 32'(bus.wr_xfr_count), 32'h0);
    chk("rst_rd_count", 32'(bus.rd_xfr_count), 32'h0);
    chk("rst_a2x_wrdt", bus.a2x_wrdt, 32'h0000_C3D4);
    reset = 1'b0;

    // 16-bit write
    bus.x2a_wrstart = 1'b1;
    step();
    bus.x2a_wrstart = 1'b0;
    bus.x2a_wrnext  = 1'b1;
    #1;
    chk("w16_b0_data", bus.a2x_wrdt, 32'h0000_C3D4);
    chk("w16_b0_next", 32'(bus.app_wr_next), 32'h0);
    chk("w16_b0_cnt", 32'(bus.wr_xfr_count), 32'h0);
    step();
    bus.x2a_wrlast = 1'b1;
    #1;
    chk("w16_b1_data", bus.a2x_wrdt, 32'h0000_A1B2);
    chk("w16_b1_next", 32'(bus.app_wr_next), 32'h1);
    chk("w16_b1_cnt", 32'(bus.wr_xfr_count), 32'h1);
    step();
    bus.x2a_wrnext = 1'b0;
    bus.x2a_wrlast = 1'b0;
    #1;
    chk("w16_end_cnt", 32'(bus.wr_xfr_count), 32'h0);

    // 8-bit write
    bus.sdr_width   = 2'b10;
    bus.app_wr_data = 32'h1122_3344;
    bus.x2a_wrnext  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("w8_data", bus.a2x_wrdt, {24'h0, wb[i]});
      chk("w8_next", 32'(bus.app_wr_next), 32'(i == 3));
      step();
    end
    bus.x2a_wrnext = 1'b0;

    // 8-bit read; upper rddt bits are junk that must be ignored
    bus.x2a_rdstart = 1'b1;
    step();
    bus.x2a_rdstart = 1'b0;
    for (int i = 0; i < 4; i++) rd_beat({24'h5AA53C, rb[i]}, i == 3);
    chk("r8_valid", 32'(bus.app_rd_valid), 32'h1);
    chk("r8_data", bus.app_rd_data, 32'hAABB_CCDD);
    step();
    chk("r8_valid_drop", 32'(bus.app_rd_valid), 32'h0);
    chk("r8_data_hold", bus.app_rd_data, 32'hAABB_CCDD);

    // 16-bit read with idle gaps
    bus.sdr_width   = 2'b01;
    bus.x2a_rdstart = 1'b1;
    step();
    bus.x2a_rdstart = 1'b0;
    rd_beat(32'hABCD_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("r16_gap_valid", 32'(bus.app_rd_valid), 32'h0);
      step();
    end
    rd_beat(32'hEEEE_1234, 1'b0);
    chk("r16_valid", 32'(bus.app_rd_valid), 32'h1);
    chk("r16_data", bus.app_rd_data, 32'h1234_5678);
    step();
    chk("r16_valid_drop", 32'(bus.app_rd_valid), 32'h0);

    // Truncated 8-bit word
    bus.sdr_width   = 2'b10;
    bus.x2a_rdstart = 1'b1;
    step();
    bus.x2a_rdstart = 1'b0;
    rd_beat(32'h0000_000F, 1'b0);
    rd_beat(32'h0000_00F0, 1'b1);
    chk("trunc_valid", 32'(bus.app_rd_valid), 32'h1);
    chk("trunc_data", bus.app_rd_data, 32'h0000_F00F);
    chk("trunc_cnt", 32'(bus.rd_xfr_count), 32'h0);
    step();

    // Reset in the middle of an 8-bit read
    bus.x2a_rdstart = 1'b1;
    step();
    bus.x2a_rdstart = 1'b0;
    rd_beat(32'h0000_0077, 1'b0);
    rd_beat(32'h0000_0088, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_valid", 32'(bus.app_rd_valid), 32'h0);
    chk("abort_data", bus.app_rd_data, 32'h0);
    chk("abort_cnt", 32'(bus.rd_xfr_count), 32'h0);
    for (int i = 0; i < 4; i++) rd_beat(32'(i + 1), i == 3);
    chk("after_rst_valid", 32'(bus.app_rd_valid), 32'h1);
    chk("after_rst_data", bus.app_rd_data, 32'h0403_0201);
    step();

    // Concurrent read and write in 16-bit mode
    bus.sdr_width   = 2'b01;
    bus.app_wr_data = 32'hCAFE_F00D;
    bus.x2a_wrstart = 1'b1;
    bus.x2a_rdstart = 1'b1;
    step();
    bus.x2a_wrstart = 1'b0;
    bus.x2a_rdstart = 1'b0;
    bus.x2a_wrnext  = 1'b1;
    bus.x2a_rdok    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.x2a_rddt = 32'h1111_0000 * 32'(i) + 32'h0000_1010 * 32'(i + 1);
      step();
    end
    bus.x2a_wrnext = 1'b0;
    bus.x2a_rdok   = 1'b0;
    chk("conc_data", bus.app_rd_data, 32'h4040_3030);
    step();

    // 32-bit pass-through, read and write together
    bus.sdr_width   = 2'b00;
    bus.app_wr_data = 32'h0BAD_BEEF;
    bus.x2a_wrnext  = 1'b1;
    bus.x2a_rdok    = 1'b1;
    bus.x2a_rddt    = 32'h8765_4321;
    #1;
    chk("w32_data", bus.a2x_wrdt, 32'h0BAD_BEEF);
    chk("w32_next", 32'(bus.app_wr_next), 32'h1);
    step();
    bus.x2a_wrnext = 1'b0;
    bus.x2a_rdok   = 1'b0;
    chk("r32_valid", 32'(bus.app_rd_valid), 32'h1);
    chk("r32_data", bus.app_rd_data, 32'h8765_4321);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
